// File: rtl/sr_latch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sr_latch_pkg                                                          |
// | Shared {s,r} request encodings and default width for the SR flag bank |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sr_latch_pkg;

  localparam int SR_WIDTH_DEFAULT = 4;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic logic sr_is_illegal(input logic [1:0] sr);
    return (sr == SR_ILLEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_4_sr_cell.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sr_cell                                                               |
// | One synchronous SR storage bit with enable and forbidden-request flag |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sr_cell
  import sr_latch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic invalid
);

  logic       r_q;
  logic       r_invalid;
  logic [1:0] w_sr;

  assign w_sr = {s, r};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= 1'b0;
      r_invalid <= 1'b0;
    end else if (!en) begin
      r_invalid <= 1'b0;
    end else begin
      // The forbidden request leaves the stored bit untouched and only raises the flag
      case (w_sr)
        SR_SET:   r_q <= 1'b1;
        SR_RESET: r_q <= 1'b0;
        default:  r_q <= r_q;
      endcase
      r_invalid <= sr_is_illegal(w_sr);
    end
  end

  assign q       = r_q;
  assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: rtl/sr_latch_4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sr_latch_4                                                            |
// | Bank of independent clocked SR flag bits sharing one enable           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sr_latch_4
  import sr_latch_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] invalid
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_invalid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .s       (s[i]),
      .r       (r[i]),
      .q       (w_q[i]),
      .invalid (w_invalid[i])
    );
  end

  // q_n is derived from the stored bit so it can never disagree with q
  assign q       = w_q;
  assign q_n     = ~w_q;
  assign invalid = w_invalid;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_4.sv
`default_nettype none
// Self-checking bench for sr_latch_4: directed scenarios then random traffic
// compared against a per-bit truth-table model.
module tb_sr_latch_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] s   = 4'h0;
  logic [3:0] r   = 4'h0;
  logic [3:0] q;
  logic [3:0] q_n;
  logic [3:0] invalid;

  logic [3:0] m_q;
  logic [3:0] m_inv;
  int         n_checks = 0;
  int         n_pass   = 0;

  sr_latch_4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .s       (s),
    .r       (r),
    .q       (q),
    .q_n     (q_n),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Apply one edge worth of stimulus, advance the model from the truth table, compare.
  task automatic step(input string tag, input logic i_rst, input logic i_en,
                      input logic [3:0] i_s, input logic [3:0] i_r);
    rst = i_rst; en = i_en; s = i_s; r = i_r;
    @(posedge clk);
    if (i_rst) begin
      m_q = 4'h0; m_inv = 4'h0;
    end else if (!i_en) begin
      m_inv = 4'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        m_inv[b] = 1'b0;
        if (i_s[b] && i_r[b])  m_inv[b] = 1'b1;
        else if (i_s[b])       m_q[b] = 1'b1;
        else if (i_r[b])       m_q[b] = 1'b0;
      end
    end
    #1;
    check({tag, ".q"}, q, m_q);
    check({tag, ".q_n"}, q_n, ~m_q);
    check({tag, ".invalid"}, invalid, m_inv);
  endtask

  initial begin
    m_q = 4'h0; m_inv = 4'h0;
    step("reset",      1'b1, 1'b1, 4'hf, 4'h0);
    check("reset_q_lit", q, 4'h0);
    check("reset_qn_lit", q_n, 4'hf);
    step("forbidden",  1'b0, 1'b1, 4'hf, 4'hf);
    check("forbidden_inv_lit", invalid, 4'hf);
    step("set",        1'b0, 1'b1, 4'hf, 4'h0);
    check("set_q_lit", q, 4'hf);
    step("hold_dis",   1'b0, 1'b0, 4'h0, 4'hf);
    check("hold_dis_q_lit", q, 4'hf);
    step("reset_r",    1'b0, 1'b1, 4'h0, 4'hf);
    check("reset_r_q_lit", q, 4'h0);
    step("mixed",      1'b0, 1'b1, 4'b1010, 4'b0110);
    check("mixed_q_lit", q, 4'b1000);
    check("mixed_inv_lit", invalid, 4'b0010);
    step("rst_over",   1'b1, 1'b1, 4'hf, 4'h0);
    check("rst_over_q_lit", q, 4'h0);
    step("set_again",  1'b0, 1'b1, 4'h5, 4'h0);
    step("inv_clear",  1'b0, 1'b1, 4'hf, 4'hf);
    step("dis_clear",  1'b0, 1'b0, 4'hf, 4'hf);
    check("dis_clear_inv_lit", invalid, 4'h0);

    for (int k = 0; k < 300; k++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
